trial_sequencer: RTL and testbench
==================================

Name: trial_sequencer

Overview:
- Round controller for the reaction timer: runs a round of 2^NUM_TRIALS_LOG2 valid trials back-to-back and re-arms the timer after each result.
- Collects each reaction time over a 4-phase handshake and tracks best time, average time and cheat count.
- Pushes per-trial and end-of-round summary values to the LCD display block over a request/acknowledge handshake.
- Sits between the reaction timer and the LCD display on the 1 ms clock domain.

Parameters:
- NUM_TRIALS_LOG2, 2, log2 of the number of valid trials per round (2 gives 4 trials).
- GAP_MS, 1500, pause between a result and the next arm, in Tick periods (16-bit counter).
- MAX_CHEATS, 3, cheats per round that abort the round (1..15).
- SLOW_TIME, 999, value recorded for a slow (timed-out) trial.

Ports:
- Clk  in  1  system clock
- Rst  in  1  reset, synchronous, active-low
- Tick  in  1  1 ms enable strobe, one Clk wide
- StartBtn  in  1  user start, level; rising edge starts a round
- TimerArm  out  1  one-cycle pulse that starts one reaction-timer trial
- ResultValid  in  1  reaction timer result ready (4-phase request)
- ResultTime  in  10  reaction time in ms, stable while ResultValid=1
- ResultCheat  in  1  trial was a cheat, qualified by ResultValid
- ResultSlow  in  1  trial was slow, qualified by ResultValid
- ResultAck  out  1  4-phase acknowledge to the reaction timer
- DispReq  out  1  display request
- DispAck  in  1  display acknowledge
- DispSel  out  2  0=TRIAL, 1=BEST, 2=AVG, 3=ABORT
- DispValue  out  10  value shown with DispSel
- TrialNum  out  4  valid trials completed this round
- BestTime  out  10  minimum recorded time this round
- AvgTime  out  10  sum >> NUM_TRIALS_LOG2, valid when Done=1
- CheatCount  out  4  cheats this round, saturates at 15
- Busy  out  1  round in progress
- Done  out  1  round finished; held until the next start

Behaviour:
- Reset (Rst=0 sampled on a Clk edge):
  - State=IDLE; all outputs 0 except BestTime=10'h3FF.
  - Sum=0, gap counter=0.
  - Reset during any state aborts immediately; no handshake is completed.
- StartBtn edge detect: StartBtn is registered; a rise is prev=0 and cur=1. A rise is accepted only in IDLE or DONE and is ignored otherwise.
- IDLE/DONE → ARM on a rise:
  - Clears TrialNum, CheatCount, Sum and Done; BestTime=3FF.
  - Sets Busy=1.
- ARM: TimerArm=1 for exactly one cycle, then → WAIT_RES.
- WAIT_RES: on ResultValid=1 the flags and time are captured, ResultAck=1 the next cycle, → ACK.
- ACK: ResultAck is held until ResultValid=0, dropped the cycle after, then the captured result is processed:
  - Cheat (Cheat has priority over Slow): CheatCount+1, saturating; TrialNum unchanged. If CheatCount reaches MAX_CHEATS → ABORT, else → GAP.
  - Slow: t=SLOW_TIME.
  - Otherwise: t=min(ResultTime, SLOW_TIME).
  - Valid trial: Sum+=t (width 10+NUM_TRIALS_LOG2, no overflow possible); BestTime=min(BestTime,t); TrialNum+1; issue display TRIAL with value t; → GAP.
- GAP: counter counts Tick up to GAP_MS.
  - If TrialNum == 2^NUM_TRIALS_LOG2 → REP_BEST.
  - Else → ARM.
  - The gap starts after any display transfer has completed.
- REP_BEST: displays BEST with value BestTime, then → REP_AVG.
- REP_AVG: AvgTime=Sum>>NUM_TRIALS_LOG2 is registered; displays AVG with value AvgTime; → DONE.
- ABORT: displays ABORT with value CheatCount, zero-extended; → DONE.
- DONE: Busy=0, Done=1.
- Display handshake:
  - DispReq rises only when DispAck=0.
  - DispSel and DispValue are stable from the DispReq rise until DispAck is sampled 1.
  - DispReq drops the cycle after DispAck=1.
  - The FSM advances only after DispAck returns to 0.
- ResultValid outside WAIT_RES is ignored and never acked.
- TimerArm never pulses while ResultAck=1.
- Tick in non-GAP states has no effect.

Test Plan:
- Round of 4 valid trials with times 250, 180, 400, 310 and a 1-cycle DispAck responder → four TRIAL displays 250, 180, 400, 310; BEST=180; AVG=285; TrialNum=4; Done=1; Busy=0.
- Trial 2 is a cheat, then 200, 200, 200, 200 → CheatCount=1, one extra TimerArm pulse (5 total), TrialNum=4, AVG=200; no TRIAL display for the cheat.
- Three consecutive cheats → ABORT display with value 3, Done=1, TrialNum=0, no BEST or AVG display.
- Slow flag on one trial with ResultTime=1023, others 100 → recorded as 999; AVG=(999+300)>>2=324; BEST=100.
- Rst=0 asserted mid-WAIT_RES while ResultValid=1 → the next cycle has all outputs 0, BestTime=3FF, ResultAck stays 0; a new StartBtn rise begins a clean round.
- StartBtn toggled during a round, and DispAck delayed by 20 cycles → the start is ignored, DispReq/DispSel/DispValue hold stable for the full delay, and the GAP count begins only after DispAck falls.

Source files
------------

// File: rtl/trial_sequencer.sv
// Round controller for the reaction timer: arms trials, collects results over a 4-phase
// handshake, keeps best/average/cheat statistics and pushes them to the LCD display block.
module trial_sequencer #(
   parameter int unsigned NUM_TRIALS_LOG2 = 2,
   parameter int unsigned GAP_MS          = 1500,
   parameter int unsigned MAX_CHEATS      = 3,
   parameter int unsigned SLOW_TIME       = 999
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tick,
   input  logic       StartBtn,
   output logic       TimerArm,
   input  logic       ResultValid,
   input  logic [9:0] ResultTime,
   input  logic       ResultCheat,
   input  logic       ResultSlow,
   output logic       ResultAck,
   output logic       DispReq,
   input  logic       DispAck,
   output logic [1:0] DispSel,
   output logic [9:0] DispValue,
   output logic [3:0] TrialNum,
   output logic [9:0] BestTime,
   output logic [9:0] AvgTime,
   output logic [3:0] CheatCount,
   output logic       Busy,
   output logic       Done
);

   localparam int unsigned SumW      = 10 + NUM_TRIALS_LOG2;
   localparam logic [3:0]  NumTrials = 4'(1 << NUM_TRIALS_LOG2);
   localparam logic [9:0]  SlowT     = 10'(SLOW_TIME);
   localparam logic [15:0] GapMs     = 16'(GAP_MS);
   localparam logic [3:0]  MaxCheats = 4'(MAX_CHEATS);

   typedef enum logic [3:0] {
      StIdle, StArm, StWaitRes, StAck, StDispTrial, StGap, StRepBest, StRepAvg, StAbort, StDone
   } state_t;

   state_t           state_q;
   state_t           next_disp;
   logic             start_q, start_prev_q, start_rise;
   logic [9:0]       res_time_q, trial_t_q, t_capped, avg_val, disp_val_n;
   logic             res_cheat_q, res_slow_q;
   logic [SumW-1:0]  sum_q;
   logic [15:0]      gap_cnt_q;
   logic [1:0]       disp_phase_q, disp_sel_n;
   logic [3:0]       cheat_next;

   always_comb begin
      start_rise = start_q & ~start_prev_q;
      t_capped   = res_slow_q ? SlowT : ((res_time_q > SlowT) ? SlowT : res_time_q);
      cheat_next = (CheatCount == 4'hF) ? CheatCount : CheatCount + 4'd1;
      avg_val    = 10'(sum_q >> NUM_TRIALS_LOG2);
      disp_sel_n = 2'd0;
      disp_val_n = 10'd0;
      next_disp  = StDone;
      unique case (state_q)
         StDispTrial: begin disp_sel_n = 2'd0; disp_val_n = trial_t_q;  next_disp = StGap;    end
         StRepBest:   begin disp_sel_n = 2'd1; disp_val_n = BestTime;   next_disp = StRepAvg; end
         StRepAvg:    begin disp_sel_n = 2'd2; disp_val_n = avg_val;    next_disp = StDone;   end
         StAbort:     begin disp_sel_n = 2'd3; disp_val_n = {6'd0, CheatCount}; end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q      <= StIdle;
         start_q      <= 1'b0;
         start_prev_q <= 1'b0;
         res_time_q   <= 10'd0;
         res_cheat_q  <= 1'b0;
         res_slow_q   <= 1'b0;
         trial_t_q    <= 10'd0;
         sum_q        <= '0;
         gap_cnt_q    <= 16'd0;
         disp_phase_q <= 2'd0;
         TimerArm     <= 1'b0;
         ResultAck    <= 1'b0;
         DispReq      <= 1'b0;
         DispSel      <= 2'd0;
         DispValue    <= 10'd0;
         TrialNum     <= 4'd0;
         BestTime     <= 10'h3FF;
         AvgTime      <= 10'd0;
         CheatCount   <= 4'd0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
      end else begin
         start_q      <= StartBtn;
         start_prev_q <= start_q;
         TimerArm     <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start_rise) begin
                  TrialNum   <= 4'd0;
                  CheatCount <= 4'd0;
                  sum_q      <= '0;
                  Done       <= 1'b0;
                  BestTime   <= 10'h3FF;
                  Busy       <= 1'b1;
                  state_q    <= StArm;
               end
            end
            StArm: begin
               TimerArm <= 1'b1;
               state_q  <= StWaitRes;
            end
            StWaitRes: begin
               if (ResultValid) begin
                  res_time_q  <= ResultTime;
                  res_cheat_q <= ResultCheat;
                  res_slow_q  <= ResultSlow;
                  ResultAck   <= 1'b1;
                  state_q     <= StAck;
               end
            end
            StAck: begin
               // Result is consumed on the same edge that releases the acknowledge.
               if (!ResultValid) begin
                  ResultAck <= 1'b0;
                  if (res_cheat_q) begin
                     CheatCount <= cheat_next;
                     gap_cnt_q  <= 16'd0;
                     state_q    <= (cheat_next >= MaxCheats) ? StAbort : StGap;
                  end else begin
                     trial_t_q <= t_capped;
                     sum_q     <= sum_q + SumW'(t_capped);
                     if (t_capped < BestTime) BestTime <= t_capped;
                     TrialNum  <= TrialNum + 4'd1;
                     state_q   <= StDispTrial;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q >= GapMs) begin
                  gap_cnt_q <= 16'd0;
                  state_q   <= (TrialNum == NumTrials) ? StRepBest : StArm;
               end else if (Tick) begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end
            StDispTrial, StRepBest, StRepAvg, StAbort: begin
               // Phases: 0 raise request, 1 await ack, 2 await ack release.
               unique case (disp_phase_q)
                  2'd0: if (!DispAck) begin
                     DispReq      <= 1'b1;
                     DispSel      <= disp_sel_n;
                     DispValue    <= disp_val_n;
                     disp_phase_q <= 2'd1;
                     if (state_q == StRepAvg) AvgTime <= avg_val;
                  end
                  2'd1: if (DispAck) begin
                     DispReq      <= 1'b0;
                     disp_phase_q <= 2'd2;
                  end
                  default: if (!DispAck) begin
                     disp_phase_q <= 2'd0;
                     gap_cnt_q    <= 16'd0;
                     state_q      <= next_disp;
                     if (next_disp == StDone) begin
                        Busy <= 1'b0;
                        Done <= 1'b1;
                     end
                  end
               endcase
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_trial_sequencer.sv
// Directed bench for trial_sequencer: reaction-timer model, display responder and a queue
// of expected display transfers.
`timescale 1ns/1ps
module tb_trial_sequencer;

   localparam int unsigned GapMs = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       timer_arm;
   logic       result_valid = 1'b0;
   logic [9:0] result_time = 10'd0;
   logic       result_cheat = 1'b0;
   logic       result_slow = 1'b0;
   logic       result_ack;
   logic       disp_req;
   logic       disp_ack = 1'b0;
   logic [1:0] disp_sel;
   logic [9:0] disp_value;
   logic [3:0] trial_num;
   logic [9:0] best_time;
   logic [9:0] avg_time;
   logic [3:0] cheat_count;
   logic       busy;
   logic       done;

   trial_sequencer #(.NUM_TRIALS_LOG2(2), .GAP_MS(GapMs), .MAX_CHEATS(3), .SLOW_TIME(999)) dut (
      .Clk(clk), .Rst(rst_n), .Tick(tick), .StartBtn(start_btn), .TimerArm(timer_arm),
      .ResultValid(result_valid), .ResultTime(result_time), .ResultCheat(result_cheat),
      .ResultSlow(result_slow), .ResultAck(result_ack), .DispReq(disp_req), .DispAck(disp_ack),
      .DispSel(disp_sel), .DispValue(disp_value), .TrialNum(trial_num), .BestTime(best_time),
      .AvgTime(avg_time), .CheatCount(cheat_count), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int arm_cnt  = 0;
   int last_arm_cyc = 0;
   int arm_ack_viol = 0;
   int arms_used    = 0;
   int ack_delay    = 0;
   int ack_fall_cyc = 0;
   logic [11:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (timer_arm) begin
         arm_cnt      <= arm_cnt + 1;
         last_arm_cyc <= cyc;
         if (result_ack) arm_ack_viol <= arm_ack_viol + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_disp(input logic [1:0] sel, input int val);
      exp_q.push_back({sel, 10'(val)});
   endtask

   task automatic disp_responder();
      logic [11:0] got, want;
      int n;
      forever begin
         @(negedge clk);
         if (disp_req && !disp_ack) begin
            got = {disp_sel, disp_value};
            chk("disp_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
               chk("disp_sel", 32'(got[11:10]), 32'(want[11:10]));
               chk("disp_value", 32'(got[9:0]), 32'(want[9:0]));
            end
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               chk("disp_stable", {19'd0, disp_req, got}, {19'd0, 1'b1, got});
            end
            disp_ack = 1'b1;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (disp_req && n < 50);
            chk("disp_req_drop", 32'(disp_req), 0);
            ack_fall_cyc = cyc;
            disp_ack = 1'b0;
         end
      end
   endtask

   task automatic wait_arm();
      int n = 0;
      while (arm_cnt <= arms_used && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("arm_seen", 32'(arm_cnt > arms_used), 1);
   endtask

   task automatic do_trial(input int t, input bit cheat, input bit slow);
      int n;
      wait_arm();
      arms_used++;
      repeat (3) @(negedge clk);
      if (!cheat) push_disp(2'd0, slow ? 999 : ((t > 999) ? 999 : t));
      result_valid = 1'b1;
      result_time  = 10'(t);
      result_cheat = cheat;
      result_slow  = slow;
      n = 0;
      while (!result_ack && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ack_rise", 32'(result_ack), 1);
      repeat (2) @(negedge clk);
      result_valid = 1'b0;
      result_time  = 10'd0;
      result_cheat = 1'b0;
      result_slow  = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (result_ack && n < 100);
      chk("ack_fall", 32'(result_ack), 0);
   endtask

   task automatic start_round(output int arm_base);
      @(negedge clk);
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      arm_base = arms_used;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("done", 32'(done), 1);
      chk("busy_clear", 32'(busy), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 tick = ~tick;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      fork
         disp_responder();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_trial_num", 32'(trial_num), 0);
      chk("rst_best", 32'(best_time), 10'h3FF);
      chk("rst_outs", {20'd0, timer_arm, result_ack, disp_req, busy, done, disp_sel, cheat_count, 1'b0},
          0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Round 1: four plain trials.
      start_round(base);
      do_trial(250, 0, 0);
      do_trial(180, 0, 0);
      do_trial(400, 0, 0);
      do_trial(310, 0, 0);
      push_disp(2'd1, 180);
      push_disp(2'd2, 285);
      wait_done();
      chk("r1_trials", 32'(trial_num), 4);
      chk("r1_best", 32'(best_time), 180);
      chk("r1_avg", 32'(avg_time), 285);
      chk("r1_cheats", 32'(cheat_count), 0);
      chk("r1_arms", 32'(arms_used - base), 4);

      // Round 2: one cheat in the second trial.
      start_round(base);
      chk("r2_busy", 32'(busy), 1);
      chk("r2_done_clr", 32'(done), 0);
      do_trial(200, 0, 0);
      do_trial(150, 1, 0);
      do_trial(200, 0, 0);
      do_trial(200, 0, 0);
      do_trial(200, 0, 0);
      push_disp(2'd1, 200);
      push_disp(2'd2, 200);
      wait_done();
      chk("r2_cheats", 32'(cheat_count), 1);
      chk("r2_trials", 32'(trial_num), 4);
      chk("r2_avg", 32'(avg_time), 200);
      chk("r2_arms", 32'(arm_cnt - base), 5);

      // Round 3: three cheats abort the round.
      start_round(base);
      do_trial(100, 1, 0);
      do_trial(100, 1, 0);
      push_disp(2'd3, 3);
      do_trial(100, 1, 0);
      wait_done();
      chk("r3_cheats", 32'(cheat_count), 3);
      chk("r3_trials", 32'(trial_num), 0);
      chk("r3_best", 32'(best_time), 10'h3FF);
      chk("r3_arms", 32'(arm_cnt - base), 3);

      // Round 4: slow trial recorded as SLOW_TIME.
      start_round(base);
      do_trial(100, 0, 0);
      do_trial(1023, 0, 1);
      do_trial(100, 0, 0);
      do_trial(100, 0, 0);
      push_disp(2'd1, 100);
      push_disp(2'd2, 324);
      wait_done();
      chk("r4_best", 32'(best_time), 100);
      chk("r4_avg", 32'(avg_time), 324);

      // Reset while a result is being offered in WAIT_RES.
      start_round(base);
      wait_arm();
      arms_used++;
      repeat (2) @(negedge clk);
      result_valid = 1'b1;
      result_time  = 10'd77;
      rst_n        = 1'b0;
      @(negedge clk);
      chk("rr_ack", 32'(result_ack), 0);
      chk("rr_best", 32'(best_time), 10'h3FF);
      chk("rr_outs", {12'd0, timer_arm, disp_req, disp_sel, disp_value, trial_num, cheat_count,
                      busy, done}, 0);
      chk("rr_avg", 32'(avg_time), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rr_idle_ack", 32'(result_ack), 0);
      result_valid = 1'b0;
      result_time  = 10'd0;
      @(negedge clk);
      arms_used = arm_cnt;
      start_round(base);
      do_trial(50, 0, 0);
      do_trial(60, 0, 0);
      do_trial(70, 0, 0);
      do_trial(80, 0, 0);
      push_disp(2'd1, 50);
      push_disp(2'd2, 65);
      wait_done();
      chk("rr_best_new", 32'(best_time), 50);
      chk("rr_avg_new", 32'(avg_time), 65);

      // Slow display acknowledge and a start press mid-round.
      ack_delay = 20;
      start_round(base);
      do_trial(300, 0, 0);
      wait_arm();
      chk("gap_after_ack", 32'((last_arm_cyc - ack_fall_cyc) >= int'(2 * GapMs - 2)), 1);
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      chk("mid_busy", 32'(busy), 1);
      do_trial(300, 0, 0);
      do_trial(300, 0, 0);
      do_trial(300, 0, 0);
      push_disp(2'd1, 300);
      push_disp(2'd2, 300);
      wait_done();
      chk("d_trials", 32'(trial_num), 4);
      chk("d_arms", 32'(arm_cnt - base), 4);
      chk("arm_vs_ack", 32'(arm_ack_viol), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
